// File: rtl/s2mm_write_controller_pkg.sv
// s2mm_write_controller_pkg: AXI constants, FSM encoding and width helper shared by the S2MM writer
package s2mm_write_controller_pkg;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_RESP
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/s2mm_write_controller_stream_fifo.sv
// stream_fifo: synchronous FIFO; a pushed word is visible at the head on the following cycle
module stream_fifo #(
   parameter int WIDTH     = 32,
   parameter int LOG_DEPTH = 5
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 i_push,
   input  logic [WIDTH-1:0]     i_data,
   input  logic                 i_pop,
   output logic [WIDTH-1:0]     o_data,
   output logic                 o_full,
   output logic                 o_empty,
   output logic [LOG_DEPTH:0]   o_count
);

   localparam int DEPTH = 1 << LOG_DEPTH;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [LOG_DEPTH:0] r_wr_ptr;
   logic [LOG_DEPTH:0] r_rd_ptr;
   logic               w_push;
   logic               w_pop;

   assign o_count = r_wr_ptr - r_rd_ptr;
   assign o_full  = o_count == (LOG_DEPTH + 1)'(DEPTH);
   assign o_empty = r_wr_ptr == r_rd_ptr;
   assign o_data  = r_mem[r_rd_ptr[LOG_DEPTH-1:0]];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Storage needs no reset; the pointers alone define which entries are valid
   always_ff @(posedge aclk)
      if (w_push) r_mem[r_wr_ptr[LOG_DEPTH-1:0]] <= i_data;

   // Pointer update; pushes when full and pops when empty are ignored
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (LOG_DEPTH + 1)'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + (LOG_DEPTH + 1)'(1);
      end

endmodule

// File: rtl/s2mm_write_controller.sv
// s2mm_write_controller: stages an AXI-Stream into a FIFO and writes it out as single-outstanding AXI4 bursts
module s2mm_write_controller
   import s2mm_write_controller_pkg::*;
#(
   parameter int MM_ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int BURST_LEN      = 16,
   parameter int FIFO_LOG_DEPTH = 5
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [4:0]                SM_log_length,
   input  logic [MM_ADDR_WIDTH-1:0]  SM_write_buffer,
   output logic                      SM_writing,
   input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   output logic [MM_ADDR_WIDTH-1:0]  m_axi_awaddr,
   output logic [7:0]                m_axi_awlen,
   output logic [2:0]                m_axi_awsize,
   output logic [1:0]                m_axi_awburst,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                      m_axi_wlast,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [7:0]                err_count
);

   localparam int SIZE_LOG = clog2(DATA_WIDTH / 8);

   state_t                   r_state;
   state_t                   w_next;
   logic [MM_ADDR_WIDTH-1:0] r_base;
   logic [4:0]               r_len_log;
   logic [4:0]               w_len_log;
   logic [31:0]              r_offset;
   logic [8:0]               r_beat;
   logic [8:0]               w_beats;
   logic [32:0]              w_buf_words;
   logic [32:0]              w_remaining;
   logic [32:0]              w_offset_sum;
   logic                     r_writing;
   logic [7:0]               r_err_count;
   logic [DATA_WIDTH-1:0]    w_fifo_data;
   logic [FIFO_LOG_DEPTH:0]  w_fifo_count;
   logic                     w_fifo_full;
   logic                     w_fifo_empty;
   logic                     w_buf_start;
   logic                     w_w_hs;
   logic                     w_b_hs;
   logic                     w_last_beat;

   stream_fifo #(
      .WIDTH     (DATA_WIDTH),
      .LOG_DEPTH (FIFO_LOG_DEPTH)
   ) u_fifo (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_push  (s_axis_tvalid),
      .i_data  (s_axis_tdata),
      .i_pop   (w_w_hs),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   // While waiting at a buffer start the live length is used, so the threshold matches what gets latched
   assign w_buf_start  = r_state == S_IDLE && r_offset == '0;
   assign w_len_log    = w_buf_start ? SM_log_length : r_len_log;
   assign w_buf_words  = 33'd1 << w_len_log;
   assign w_remaining  = w_buf_words - {1'b0, r_offset};
   assign w_beats      = (w_remaining < 33'(BURST_LEN)) ? 9'(w_remaining) : 9'(BURST_LEN);
   assign w_offset_sum = {1'b0, r_offset} + 33'(w_beats);
   assign w_last_beat  = r_beat == w_beats - 9'd1;
   assign w_w_hs       = r_state == S_DATA && !w_fifo_empty && m_axi_wready;
   assign w_b_hs       = r_state == S_RESP && m_axi_bvalid;

   assign s_axis_tready = !w_fifo_full;
   assign m_axi_awaddr  = r_base + (MM_ADDR_WIDTH'(r_offset) << SIZE_LOG);
   assign m_axi_awlen   = 8'(w_beats - 9'd1);
   assign m_axi_awsize  = 3'(SIZE_LOG);
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_wdata   = w_fifo_data;
   assign m_axi_wstrb   = '1;
   assign SM_writing    = r_writing;
   assign err_count     = r_err_count;

   // Next state and channel handshake outputs
   always_comb begin
      w_next        = r_state;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      m_axi_bready  = 1'b0;
      case (r_state)
         S_IDLE: if (32'(w_fifo_count) >= 32'(w_beats)) w_next = S_ADDR;
         S_ADDR: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) w_next = S_DATA;
         end
         S_DATA: begin
            m_axi_wvalid = !w_fifo_empty;
            m_axi_wlast  = w_last_beat;
            if (w_w_hs && w_last_beat) w_next = S_RESP;
         end
         S_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State, buffer context, beat/offset progress, write pulse and error counter
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_len_log   <= '0;
         r_offset    <= '0;
         r_beat      <= '0;
         r_writing   <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_state   <= w_next;
         r_writing <= w_w_hs;
         if (w_buf_start) begin
            r_base    <= SM_write_buffer;
            r_len_log <= SM_log_length;
         end
         if (w_w_hs) r_beat <= w_last_beat ? '0 : r_beat + 9'd1;
         if (w_b_hs) r_offset <= (w_offset_sum == w_buf_words) ? '0 : 32'(w_offset_sum);
         if (w_b_hs && m_axi_bresp != RESP_OKAY && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end

endmodule

// File: tb/tb_s2mm_write_controller.sv
// tb_s2mm_write_controller: directed scenarios with an AXI slave responder and stream scoreboard
module tb_s2mm_write_controller;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [4:0]  SM_log_length;
   logic [31:0] SM_write_buffer;
   logic        SM_writing;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] m_axi_awaddr;
   logic [7:0]  m_axi_awlen;
   logic [2:0]  m_axi_awsize;
   logic [1:0]  m_axi_awburst;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wlast;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_bvalid;
   logic        m_axi_bready;
   logic [7:0]  err_count;

   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 0;
   bit          stall = 0;
   bit          gaps = 0;
   int          err_left = 0;
   logic [31:0] src_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] aw_addr_q[$];
   logic [7:0]  aw_len_q[$];
   int          bursts = 0;
   int          pulses = 0;
   int          w_total = 0;
   int          wlast_cnt = 0;
   int          beat = 0;
   logic [7:0]  cur_len = '0;
   bit          in_burst = 0;
   bit          b_pending = 0;
   bit          aw_wait = 0;
   bit          w_wait = 0;
   logic [31:0] aw_hold = '0;
   logic [31:0] w_hold = '0;

   s2mm_write_controller dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .SM_log_length   (SM_log_length),
      .SM_write_buffer (SM_write_buffer),
      .SM_writing      (SM_writing),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .m_axi_awaddr    (m_axi_awaddr),
      .m_axi_awlen     (m_axi_awlen),
      .m_axi_awsize    (m_axi_awsize),
      .m_axi_awburst   (m_axi_awburst),
      .m_axi_awvalid   (m_axi_awvalid),
      .m_axi_awready   (m_axi_awready),
      .m_axi_wdata     (m_axi_wdata),
      .m_axi_wstrb     (m_axi_wstrb),
      .m_axi_wlast     (m_axi_wlast),
      .m_axi_wvalid    (m_axi_wvalid),
      .m_axi_wready    (m_axi_wready),
      .m_axi_bresp     (m_axi_bresp),
      .m_axi_bvalid    (m_axi_bvalid),
      .m_axi_bready    (m_axi_bready),
      .err_count       (err_count)
   );

   always #5 aclk = ~aclk;

   // Observes the handshakes that will complete at the coming rising edge
   task automatic monitor();
      logic [31:0] exp;
      if (aw_wait) begin
         checks++;
         if (m_axi_awvalid !== 1'b1 || m_axi_awaddr !== aw_hold) begin
            errors++;
            $display("FAIL aw_stable: awvalid=%0b awaddr=%h, required awvalid=1 awaddr=%h", m_axi_awvalid, m_axi_awaddr, aw_hold);
         end
      end
      if (w_wait) begin
         checks++;
         if (m_axi_wvalid !== 1'b1 || m_axi_wdata !== w_hold) begin
            errors++;
            $display("FAIL w_stable: wvalid=%0b wdata=%h, required wvalid=1 wdata=%h", m_axi_wvalid, m_axi_wdata, w_hold);
         end
      end
      if (m_axi_wvalid) begin
         checks++;
         if (!in_burst) begin
            errors++;
            $display("FAIL w_before_aw: wvalid=1 with no accepted AW, required wvalid=0");
         end
      end
      if (m_axi_awvalid && m_axi_awready) begin
         checks++;
         if (in_burst || b_pending) begin
            errors++;
            $display("FAIL aw_outstanding: second AW at %h before B, required none", m_axi_awaddr);
         end
         checks++;
         if (m_axi_awsize !== 3'd2 || m_axi_awburst !== 2'b01) begin
            errors++;
            $display("FAIL aw_fields: awsize=%0d awburst=%0d, required awsize=2 awburst=1", m_axi_awsize, m_axi_awburst);
         end
         aw_addr_q.push_back(m_axi_awaddr);
         aw_len_q.push_back(m_axi_awlen);
         cur_len = m_axi_awlen;
         beat = 0;
         in_burst = 1;
      end else if (m_axi_wvalid && m_axi_wready && in_burst) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL w_data: wdata=%h with nothing outstanding, required no beat", m_axi_wdata);
         end else begin
            exp = exp_q.pop_front();
            if (m_axi_wdata !== exp) begin
               errors++;
               $display("FAIL w_data: wdata=%h, required %h", m_axi_wdata, exp);
            end
         end
         checks++;
         if (m_axi_wlast !== (beat == int'(cur_len)) || m_axi_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL w_last: wlast=%0b wstrb=%h at beat %0d of len %0d, required wlast=%0b wstrb=f", m_axi_wlast, m_axi_wstrb, beat, cur_len, beat == int'(cur_len));
         end
         if (m_axi_wlast) wlast_cnt++;
         w_total++;
         if (beat == int'(cur_len)) begin
            in_burst = 0;
            b_pending = 1;
         end
         beat++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
         b_pending = 0;
         bursts++;
         if (err_left > 0) err_left--;
      end
      if (SM_writing) pulses++;
      if (s_axis_tvalid && s_axis_tready) exp_q.push_back(src_q.pop_front());
      aw_wait = m_axi_awvalid && !m_axi_awready;
      aw_hold = m_axi_awaddr;
      w_wait = m_axi_wvalid && !m_axi_wready;
      w_hold = m_axi_wdata;
   endtask

   // Stream source and AXI slave: drive on the falling edge, observe 1 ns later
   initial begin
      forever begin
         @(negedge aclk);
         if (!mon_en) begin
            s_axis_tvalid = 0;
            m_axi_awready = 0;
            m_axi_wready = 0;
            m_axi_bvalid = 0;
         end else begin
            s_axis_tvalid = src_q.size() > 0 && !(gaps && $urandom_range(2) == 0);
            s_axis_tdata = src_q.size() > 0 ? src_q[0] : 32'h0;
            m_axi_awready = !stall || $urandom_range(1) == 1;
            m_axi_wready = !stall || $urandom_range(3) != 0;
            m_axi_bvalid = b_pending && (!stall || $urandom_range(1) == 1);
            m_axi_bresp = err_left > 0 ? 2'b10 : 2'b00;
            #1;
            if (mon_en) monitor();
         end
      end
   end

   function automatic int progress(input int sel);
      return sel == 0 ? aw_addr_q.size() : sel == 1 ? bursts : w_total;
   endfunction

   task automatic wait_for(input string what, input int sel, input int n, input int budget);
      int c;
      c = 0;
      while (progress(sel) < n && c < budget) begin
         @(negedge aclk);
         c++;
      end
      checks++;
      if (progress(sel) < n) begin
         errors++;
         $display("FAIL timeout_%s: reached %0d, required %0d within %0d cycles", what, progress(sel), n, budget);
      end
   endtask

   task automatic do_reset();
      mon_en = 0;
      aresetn = 0;
      src_q.delete();
      exp_q.delete();
      aw_addr_q.delete();
      aw_len_q.delete();
      bursts = 0;
      pulses = 0;
      w_total = 0;
      wlast_cnt = 0;
      in_burst = 0;
      b_pending = 0;
      aw_wait = 0;
      w_wait = 0;
      stall = 0;
      gaps = 0;
      err_left = 0;
      repeat (2) @(negedge aclk);
      aresetn = 1;
      @(negedge aclk);
      mon_en = 1;
   endtask

   task automatic send(input logic [31:0] first, input int n);
      for (int i = 0; i < n; i++) src_q.push_back(first + 32'(i));
   endtask

   task automatic test_reset();
      mon_en = 0;
      aresetn = 0;
      #3;
      checks++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, SM_writing} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: aw/w/wlast/b/writing=%b, required 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, SM_writing});
      end
      checks++;
      if (err_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_err_count: %0d, required 0", err_count);
      end
      checks++;
      if (s_axis_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_tready: %b, required 1 (FIFO empty)", s_axis_tready);
      end
      do_reset();
   endtask

   task automatic test_continuous();
      logic [31:0] exp_addr[5];
      exp_addr = '{32'h0001_0000, 32'h0001_0040, 32'h0001_0080, 32'h0001_00C0, 32'h0002_0000};
      do_reset();
      SM_log_length = 5'd6;
      SM_write_buffer = 32'h0001_0000;
      send(32'hA000_0000, 80);
      wait_for("cont_aw4", 0, 4, 600);
      SM_write_buffer = 32'h0002_0000;
      wait_for("cont_bursts", 1, 5, 600);
      repeat (3) @(negedge aclk);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (aw_addr_q[i] !== exp_addr[i] || aw_len_q[i] !== 8'd15) begin
            errors++;
            $display("FAIL cont_aw%0d: addr=%h len=%0d, required addr=%h len=15", i, aw_addr_q[i], aw_len_q[i], exp_addr[i]);
         end
      end
      checks++;
      if (pulses != 80 || w_total != 80 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL cont_pulses: pulses=%0d beats=%0d left=%0d, required 80 80 0", pulses, w_total, exp_q.size());
      end
   endtask

   task automatic test_short_buffer();
      do_reset();
      SM_log_length = 5'd2;
      SM_write_buffer = 32'h0000_3000;
      send(32'hB000_0000, 12);
      wait_for("short_bursts", 1, 3, 300);
      repeat (2) @(negedge aclk);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (aw_addr_q[i] !== 32'h0000_3000 || aw_len_q[i] !== 8'd3) begin
            errors++;
            $display("FAIL short_aw%0d: addr=%h len=%0d, required addr=00003000 len=3", i, aw_addr_q[i], aw_len_q[i]);
         end
      end
      checks++;
      if (wlast_cnt != 3 || pulses != 12) begin
         errors++;
         $display("FAIL short_wlast: wlast=%0d pulses=%0d, required 3 12", wlast_cnt, pulses);
      end
      do_reset();
      SM_log_length = 5'd0;
      SM_write_buffer = 32'h0000_4000;
      send(32'hC000_0000, 2);
      wait_for("one_bursts", 1, 2, 200);
      repeat (2) @(negedge aclk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (aw_addr_q[i] !== 32'h0000_4000 || aw_len_q[i] !== 8'd0) begin
            errors++;
            $display("FAIL one_aw%0d: addr=%h len=%0d, required addr=00004000 len=0", i, aw_addr_q[i], aw_len_q[i]);
         end
      end
      checks++;
      if (wlast_cnt != 2 || pulses != 2) begin
         errors++;
         $display("FAIL one_wlast: wlast=%0d pulses=%0d, required 2 2", wlast_cnt, pulses);
      end
   endtask

   task automatic test_base_change();
      logic [31:0] exp_addr[4];
      exp_addr = '{32'h0000_1000, 32'h0000_1040, 32'h0000_2000, 32'h0000_2040};
      do_reset();
      SM_log_length = 5'd5;
      SM_write_buffer = 32'h0000_1000;
      send(32'hD000_0000, 64);
      wait_for("base_aw1", 0, 1, 200);
      SM_write_buffer = 32'h0000_2000;
      wait_for("base_bursts", 1, 4, 600);
      repeat (2) @(negedge aclk);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (aw_addr_q[i] !== exp_addr[i]) begin
            errors++;
            $display("FAIL base_aw%0d: addr=%h, required %h", i, aw_addr_q[i], exp_addr[i]);
         end
      end
      checks++;
      if (pulses != 64) begin
         errors++;
         $display("FAIL base_pulses: %0d, required 64", pulses);
      end
   endtask

   task automatic test_stalls();
      do_reset();
      stall = 1;
      gaps = 1;
      SM_log_length = 5'd6;
      SM_write_buffer = 32'h0000_5000;
      for (int i = 0; i < 64; i++) src_q.push_back($urandom);
      wait_for("stall_bursts", 1, 4, 3000);
      repeat (3) @(negedge aclk);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (aw_addr_q[i] !== 32'h0000_5000 + 32'(i * 64)) begin
            errors++;
            $display("FAIL stall_aw%0d: addr=%h, required %h", i, aw_addr_q[i], 32'h0000_5000 + 32'(i * 64));
         end
      end
      checks++;
      if (pulses != 64 || exp_q.size() != 0 || src_q.size() != 0) begin
         errors++;
         $display("FAIL stall_totals: pulses=%0d fifo_left=%0d src_left=%0d, required 64 0 0", pulses, exp_q.size(), src_q.size());
      end
   endtask

   task automatic test_errors();
      do_reset();
      SM_log_length = 5'd6;
      SM_write_buffer = 32'h0000_6000;
      err_left = 3;
      send(32'hE000_0000, 48);
      wait_for("err_bursts3", 1, 3, 600);
      repeat (2) @(negedge aclk);
      checks++;
      if (err_count !== 8'd3) begin
         errors++;
         $display("FAIL err_count3: %0d, required 3", err_count);
      end
      checks++;
      if (aw_addr_q[1] !== 32'h0000_6040 || aw_addr_q[2] !== 32'h0000_6080) begin
         errors++;
         $display("FAIL err_offset: addr1=%h addr2=%h, required 00006040 00006080", aw_addr_q[1], aw_addr_q[2]);
      end
      err_left = 300;
      send(32'hF000_0000, 4800);
      wait_for("err_bursts303", 1, 303, 9000);
      repeat (2) @(negedge aclk);
      checks++;
      if (err_count !== 8'd255) begin
         errors++;
         $display("FAIL err_saturate: %0d, required 255", err_count);
      end
      checks++;
      if (aw_addr_q[3] !== 32'h0000_60C0 || aw_addr_q[4] !== 32'h0000_6000 || aw_addr_q[302] !== 32'h0000_6080) begin
         errors++;
         $display("FAIL err_wrap: addr3=%h addr4=%h addr302=%h, required 000060c0 00006000 00006080", aw_addr_q[3], aw_addr_q[4], aw_addr_q[302]);
      end
      checks++;
      if (w_total != 4848) begin
         errors++;
         $display("FAIL err_beats: %0d, required 4848", w_total);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      SM_log_length = 5'd6;
      SM_write_buffer = 32'h0000_7000;
      send(32'h7000_0000, 32);
      wait_for("mid_beats4", 2, 4, 200);
      mon_en = 0;
      aresetn = 0;
      #1;
      checks++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, SM_writing} !== 5'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs: aw/w/wlast/b/writing=%b, required 00000", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, SM_writing});
      end
      checks++;
      if (err_count !== 8'd0 || s_axis_tready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_state: err_count=%0d tready=%b, required 0 1", err_count, s_axis_tready);
      end
      do_reset();
      send(32'h9000_0000, 16);
      wait_for("mid_after", 1, 1, 300);
      repeat (2) @(negedge aclk);
      checks++;
      if (aw_addr_q[0] !== 32'h0000_7000 || aw_len_q[0] !== 8'd15) begin
         errors++;
         $display("FAIL mid_first_aw: addr=%h len=%0d, required 00007000 15", aw_addr_q[0], aw_len_q[0]);
      end
      checks++;
      if (pulses != 16 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL mid_totals: pulses=%0d left=%0d, required 16 0", pulses, exp_q.size());
      end
   endtask

   initial begin
      SM_log_length = 5'd6;
      SM_write_buffer = 32'h0;
      s_axis_tdata = 32'h0;
      s_axis_tvalid = 0;
      m_axi_awready = 0;
      m_axi_wready = 0;
      m_axi_bresp = 2'b00;
      m_axi_bvalid = 0;
      test_reset();
      test_continuous();
      test_short_buffer();
      test_base_change();
      test_stalls();
      test_errors();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, required completion before 900000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/s2mm_write_controller.md
# s2mm_write_controller

Sequences stream-to-memory transfers into the quad-buffer scheme. It accepts sample words on an AXI-Stream slave and stages them in a small FIFO. It then issues single-outstanding AXI4 write bursts to the address supplied by the buffer manager (`SM_write_buffer`) and pulses `SM_writing` once per accepted data beat, so the manager can advance its write counter and rotate buffers. It sits between the signal-processing stream and the HP/ACP memory port.

## Interface
- `MM_ADDR_WIDTH`, 32, memory-mapped address width
- `DATA_WIDTH`, 32, stream and AXI data width in bits; byte stride is DATA_WIDTH/8
- `BURST_LEN`, 16, maximum beats per AXI burst (power of two, 2..256)
- `FIFO_LOG_DEPTH`, 5, log2 of staging FIFO depth; depth must be ≥ BURST_LEN
- `aclk` in 1: single clock for all logic
- `aresetn` in 1: asynchronous assert, active-low reset
- `SM_log_length` in 5: buffer holds 2^SM_log_length words
- `SM_write_buffer` in MM_ADDR_WIDTH: byte base of current write buffer
- `SM_writing` out 1: one-cycle pulse per W beat written
- `s_axis_tdata` in DATA_WIDTH, `s_axis_tvalid` in 1, `s_axis_tready` out 1: sample stream
- `m_axi_awaddr` out MM_ADDR_WIDTH, `m_axi_awlen` out 8, `m_axi_awsize` out 3, `m_axi_awburst` out 2, `m_axi_awvalid` out 1, `m_axi_awready` in 1
- `m_axi_wdata` out DATA_WIDTH, `m_axi_wstrb` out DATA_WIDTH/8, `m_axi_wlast` out 1, `m_axi_wvalid` out 1, `m_axi_wready` in 1
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1
- `err_count` out 8: saturating count of non-OKAY BRESP

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - On entry with `offset == 0`, latch `SM_write_buffer` into `base` and `SM_log_length` into `len_log`.
  - `beats = min(BURST_LEN, 2^len_log - offset)`.
  - Move to ADDR when FIFO count ≥ `beats`.
- ADDR: drive `awaddr = base + offset*DATA_WIDTH/8` and `awlen = beats-1`. Constant fields: `awsize = log2(DATA_WIDTH/8)`, `awburst = INCR`. On the AW handshake, go to DATA.
- DATA:
  - `wvalid` = FIFO not empty; `wdata` = FIFO head; `wstrb` all ones.
  - `wlast` is high on beat `beats-1`.
  - Each W handshake pops the FIFO and increments the beat counter.
  - After the last beat, go to RESP.
- RESP: `bready = 1`. On `bvalid`:
  - if `bresp != 0`, increment `err_count` (saturate at 255);
  - `offset += beats`, wrapping to 0 when it reaches `2^len_log`;
  - return to IDLE.
- Bursts never cross the buffer end. `SM_write_buffer` must be aligned to BURST_LEN*DATA_WIDTH/8 so no burst crosses 4 KB; this block does not check alignment.
- `SM_log_length` changes take effect only at the next buffer start (`offset == 0`).
- Stream side: `s_axis_tready` = FIFO not full. Data is never dropped; back-pressure only.
- Simultaneous FIFO push and pop in one cycle is legal; count is unchanged.
- `SM_log_length < log2(BURST_LEN)`: bursts shrink to the buffer size. `SM_log_length = 0` gives one-beat bursts.

## Timing
- Reset values: all valids 0, `bready` 0, `wlast` 0, `SM_writing` 0, `err_count` 0, `offset` 0, FIFO empty, FSM in IDLE.
- Reset assertion mid-burst aborts immediately; no completion of an outstanding AXI transaction is attempted.
- `awvalid` rises 1 cycle after the FIFO threshold is met in IDLE. It stays high until `awready` and is not withdrawn.
- `wvalid` may first rise in the cycle after the AW handshake. W data never precedes AW.
- `SM_writing` is registered: it pulses the cycle after each W handshake, giving exactly `beats` pulses per burst.
- Only one burst is outstanding. The next `awvalid` can be no earlier than 1 cycle after the `bvalid` handshake.
- FIFO latency: a word accepted on the stream in cycle n is visible at the head in cycle n+1.

## Structure
- Shared package holds:
  - AXI constants: `BURST_INCR = 2'b01`, `RESP_OKAY = 2'b00`;
  - FSM state encoding;
  - function `clog2` for the `awsize` and FIFO pointer widths.
- One sub-module, `stream_fifo`:
  - synchronous FIFO with parameterised width and log depth;
  - ports push/pop/full/empty/count;
  - async active-low reset.

## Test plan
- Continuous stream, `SM_log_length = 6`, `BURST_LEN = 16`, `wready`/`awready` always 1 → 4 bursts at offsets 0x00, 0x40, 0x80, 0xC0 from base, `awlen = 15`, 64 `SM_writing` pulses, then `offset` wraps and `base` is re-latched.
- `SM_log_length = 2`, `BURST_LEN = 16` → every burst has `awlen = 3` at the same base address; `wlast` on the 4th beat.
- `SM_write_buffer` changes from 0x1000 to 0x2000 mid-buffer → the remaining bursts of that buffer still use 0x1000; the first burst of the next buffer uses 0x2000.
- Random `wready`/`awready` stalls plus `s_axis_tvalid` gaps → no data loss or reordering (scoreboard vs input), `awvalid`/`wvalid` stable while stalled, no second AW before B.
- `bresp = 2'b10` on 3 bursts, then 300 error bursts → `err_count` reads 3, then saturates at 255; `offset` still advances.
- `aresetn` pulled low during DATA beat 5 of 16 → all outputs return to reset values asynchronously; after release the first burst starts at offset 0 with the FIFO empty.
